// File: rtl/hamming_scrub_sched_if.sv
// Control/status bundle between the scrub scheduler and its controller.
// The master side drives run/err_in/clear_err; the slave (scheduler) drives status.
interface hamming_scrub_sched_if #(
    parameter int unsigned ERR_W   = 8,
    parameter int unsigned SCRUB_W = 16
);
    logic               run;
    logic               err_in;
    logic               clear_err;
    logic               enable;
    logic               scrub_active;
    logic               scrub_done;
    logic               err_seen;
    logic [ERR_W-1:0]   err_count;
    logic [SCRUB_W-1:0] scrub_count;

    modport master (
        output run, err_in, clear_err,
        input  enable, scrub_active, scrub_done, err_seen, err_count, scrub_count
    );

    modport slave (
        input  run, err_in, clear_err,
        output enable, scrub_active, scrub_done, err_seen, err_count, scrub_count
    );
endinterface

// File: rtl/hamming_scrub_sched.sv
// Enable scheduler for the Hamming-protected counter: PERIOD-cycle bursts, each closed by an
// enable-low scrub window (ENCODE, CHECK, DONE) that counts windows and errored windows.
module hamming_scrub_sched #(
    parameter int unsigned PERIOD       = 16,
    parameter int unsigned CHECK_CYCLES = 3,
    parameter int unsigned ERR_W        = 8,
    parameter int unsigned SCRUB_W      = 16
) (
    input logic                   clk,
    input logic                   rst,
    hamming_scrub_sched_if.slave  bus
);
    localparam int unsigned BW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned CW = $clog2(CHECK_CYCLES);

    localparam logic [BW-1:0]    BurstLast = BW'(PERIOD - 1);
    localparam logic [CW-1:0]    ChkLast   = CW'(CHECK_CYCLES - 1);
    localparam logic [ERR_W-1:0] ErrMax    = '1;

    typedef enum logic [2:0] {StIdle, StCount, StEncode, StCheck, StDone} state_e;

    state_e             state_q, state_d;
    logic [BW-1:0]      burst_q, burst_d;
    logic [CW-1:0]      chk_q, chk_d;
    logic               win_err_q, win_err_d;
    logic               err_seen_q, err_seen_d;
    logic [ERR_W-1:0]   err_count_q, err_count_d;
    logic [SCRUB_W-1:0] scrub_count_q, scrub_count_d;
    logic               enable_q, enable_d;
    logic               active_q, active_d;
    logic               done_q, done_d;
    logic               done_err;

    always_comb begin
        state_d       = state_q;
        burst_d       = burst_q;
        chk_d         = chk_q;
        win_err_d     = win_err_q;
        scrub_count_d = scrub_count_q;

        unique case (state_q)
            StIdle: begin
                if (bus.run) begin
                    state_d = StCount;
                    burst_d = '0;
                end
            end
            StCount: begin
                burst_d = burst_q + 1'b1;
                if (burst_q == BurstLast || !bus.run) state_d = StEncode;
            end
            StEncode: begin
                state_d   = StCheck;
                chk_d     = '0;
                win_err_d = 1'b0;
            end
            StCheck: begin
                // run is deliberately not sampled here; the window always completes.
                win_err_d = win_err_q | bus.err_in;
                chk_d     = chk_q + 1'b1;
                if (chk_q == ChkLast) state_d = StDone;
            end
            StDone: begin
                scrub_count_d = scrub_count_q + 1'b1;
                burst_d       = '0;
                state_d       = bus.run ? StCount : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // An errored DONE coinciding with clear_err survives the clear as a single count.
    always_comb begin
        err_count_d = err_count_q;
        err_seen_d  = err_seen_q;
        done_err    = (state_q == StDone) && win_err_q;
        if (bus.clear_err) begin
            err_count_d = ERR_W'(done_err);
            err_seen_d  = done_err;
        end else if (done_err) begin
            err_seen_d = 1'b1;
            if (err_count_q != ErrMax) err_count_d = err_count_q + 1'b1;
        end
    end

    always_comb begin
        enable_d = (state_d == StCount);
        active_d = (state_d == StEncode) || (state_d == StCheck) || (state_d == StDone);
        done_d   = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            burst_q       <= '0;
            chk_q         <= '0;
            win_err_q     <= 1'b0;
            err_seen_q    <= 1'b0;
            err_count_q   <= '0;
            scrub_count_q <= '0;
            enable_q      <= 1'b0;
            active_q      <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            burst_q       <= burst_d;
            chk_q         <= chk_d;
            win_err_q     <= win_err_d;
            err_seen_q    <= err_seen_d;
            err_count_q   <= err_count_d;
            scrub_count_q <= scrub_count_d;
            enable_q      <= enable_d;
            active_q      <= active_d;
            done_q        <= done_d;
        end
    end

    assign bus.enable       = enable_q;
    assign bus.scrub_active = active_q;
    assign bus.scrub_done   = done_q;
    assign bus.err_seen     = err_seen_q;
    assign bus.err_count    = err_count_q;
    assign bus.scrub_count  = scrub_count_q;
endmodule

// File: tb/tb_hamming_scrub_sched.sv
// Directed bench for hamming_scrub_sched: a frame-position model checked every cycle, plus
// hand-computed literal expectations at key points.
module tb_hamming_scrub_sched;
    localparam int P  = 4;
    localparam int C  = 3;
    localparam int DP = P + C + 1;  // frame position of the DONE cycle

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hamming_scrub_sched_if #(.ERR_W(8), .SCRUB_W(16)) bus ();

    hamming_scrub_sched #(
        .PERIOD      (P),
        .CHECK_CYCLES(C),
        .ERR_W       (8),
        .SCRUB_W     (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: idle flag plus position within a frame (0..P-1 count, P encode, check, DP done).
    bit m_idle;
    int m_pos;
    bit m_werr;
    int m_errc;
    bit m_seen;
    int m_scrubs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_idle = 1'b1; m_pos = 0; m_werr = 1'b0; m_errc = 0; m_seen = 1'b0; m_scrubs = 0;
    endtask

    task automatic model_step(input bit run, input bit err, input bit clr);
        bit hit;
        hit = !m_idle && m_pos == DP && m_werr;
        if (m_idle) begin
            if (run) begin m_idle = 1'b0; m_pos = 0; end
        end else if (m_pos < P) begin
            m_pos = (m_pos == P - 1 || !run) ? P : m_pos + 1;
        end else if (m_pos == P) begin
            m_pos++;
            m_werr = 1'b0;
        end else if (m_pos < DP) begin
            m_werr |= err;
            m_pos++;
        end else begin
            m_scrubs = (m_scrubs + 1) % 65536;
            if (run) m_pos = 0; else m_idle = 1'b1;
        end
        if (clr) begin
            m_errc = hit ? 1 : 0;
            m_seen = hit;
        end else if (hit) begin
            m_seen = 1'b1;
            if (m_errc < 255) m_errc++;
        end
    endtask

    task automatic compare_all();
        check("enable",       32'(bus.enable),       32'(!m_idle && m_pos < P));
        check("scrub_active", 32'(bus.scrub_active), 32'(!m_idle && m_pos >= P));
        check("scrub_done",   32'(bus.scrub_done),   32'(!m_idle && m_pos == DP));
        check("err_seen",     32'(bus.err_seen),     32'(m_seen));
        check("err_count",    32'(bus.err_count),    32'(m_errc));
        check("scrub_count",  32'(bus.scrub_count),  32'(m_scrubs));
    endtask

    // Called at a falling edge: apply inputs, advance model at the rising edge, compare after.
    task automatic cycle(input bit run, input bit err, input bit clr);
        bus.run = run; bus.err_in = err; bus.clear_err = clr;
        @(posedge clk);
        if (rst) model_reset(); else model_step(run, err, clr);
        @(negedge clk);
        compare_all();
    endtask

    logic [8:0] en_pat, dn_pat;

    initial begin
        bus.run = 1'b0; bus.err_in = 1'b0; bus.clear_err = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        check("rst_enable", 32'(bus.enable), 32'd0);
        check("rst_scrub_count", 32'(bus.scrub_count), 32'd0);
        rst = 1'b0;

        // Steady run: 1111 00000 with DONE on the 9th cycle, repeated.
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 9; i++) begin
                cycle(1, 0, 0);
                en_pat[8-i] = bus.enable;
                dn_pat[8-i] = bus.scrub_done;
            end
            check("enable_pattern", 32'(en_pat), 32'h1E0);
            check("done_pattern",   32'(dn_pat), 32'h001);
        end
        repeat (10) cycle(1, 0, 0);
        check("scrub_count_27", 32'(bus.scrub_count), 32'd3);

        // Error pulse at the 2nd CHECK cycle.
        repeat (6) cycle(1, 0, 0);
        cycle(1, 1, 0);
        repeat (2) cycle(1, 0, 0);
        check("err_count_win", 32'(bus.err_count), 32'd1);
        check("err_seen_win",  32'(bus.err_seen),  32'd1);
        check("scrub_count_4", 32'(bus.scrub_count), 32'd4);

        // Clear, then err_in only during COUNT and ENCODE: ignored.
        cycle(1, 1, 1);
        repeat (4) cycle(1, 1, 0);
        repeat (4) cycle(1, 0, 0);
        check("err_count_outside", 32'(bus.err_count), 32'd0);
        check("err_seen_outside",  32'(bus.err_seen),  32'd0);
        check("scrub_count_5",     32'(bus.scrub_count), 32'd5);

        // Errored window, then clear_err coinciding with a second errored DONE.
        repeat (6) cycle(1, 0, 0);
        cycle(1, 1, 0);
        repeat (2) cycle(1, 0, 0);
        check("err_count_pre_clr", 32'(bus.err_count), 32'd1);
        repeat (6) cycle(1, 0, 0);
        cycle(1, 1, 0);
        cycle(1, 0, 0);
        cycle(1, 0, 1);
        check("err_count_clr_done", 32'(bus.err_count), 32'd1);
        check("err_seen_clr_done",  32'(bus.err_seen),  32'd1);

        // Asynchronous reset in the middle of CHECK.
        repeat (6) cycle(1, 1, 0);
        check("mid_check_active", 32'(bus.scrub_active), 32'd1);
        #2 rst = 1'b1;
        #1 model_reset();
        compare_all();
        check("rst_async_enable", 32'(bus.enable),       32'd0);
        check("rst_async_active", 32'(bus.scrub_active), 32'd0);
        check("rst_async_done",   32'(bus.scrub_done),   32'd0);
        check("rst_async_errc",   32'(bus.err_count),    32'd0);
        check("rst_async_scrub",  32'(bus.scrub_count),  32'd0);
        cycle(0, 1, 0);
        rst = 1'b0;
        cycle(0, 0, 0);
        check("post_rst_done", 32'(bus.scrub_done), 32'd0);

        // run dropped during the 2nd COUNT cycle: single window, then IDLE.
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        cycle(0, 0, 0);
        check("stop_enable",  32'(bus.enable),       32'd0);
        check("stop_encode",  32'(bus.scrub_active), 32'd1);
        repeat (4) cycle(0, 0, 0);
        check("stop_done",    32'(bus.scrub_done),   32'd1);
        cycle(0, 0, 0);
        check("stop_scrub_count", 32'(bus.scrub_count), 32'd1);
        repeat (5) cycle(0, 0, 0);
        check("stop_idle_enable", 32'(bus.enable), 32'd0);
        check("stop_idle_active", 32'(bus.scrub_active), 32'd0);

        // err_in held for 300 windows: err_count saturates.
        rst = 1'b1;
        cycle(0, 0, 0);
        rst = 1'b0;
        cycle(1, 1, 0);
        repeat (300 * 9) cycle(1, 1, 0);
        check("sat_err_count",   32'(bus.err_count),   32'd255);
        check("sat_err_seen",    32'(bus.err_seen),    32'd1);
        check("sat_scrub_count", 32'(bus.scrub_count), 32'd300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
